// File: rtl/qam16_mod.sv
// 16-QAM modulator: Gray-mapped I/Q levels are mixed with an external cos/sin
// carrier. The output is I*cos - Q*sin, which appears 2 clock edges after the carrier sample.
module qam16_mod #(
    parameter int SPS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sym_valid,
    input  logic [3:0]         sym,
    output logic               sym_ready,
    input  logic signed [7:0]  cos,
    input  logic signed [7:0]  sin,
    output logic signed [10:0] mod_out,
    output logic               mod_valid,
    output logic               sym_start,
    output logic               underrun
);
    localparam int STAGES = 2;
    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic signed [2:0]     lvl_i, lvl_q;
    logic                  xfer, run;
    logic [STAGES:1]       vld_pipe, sop_pipe;
    logic signed [9:0]     pi, pq, prod_i, prod_q;
    logic signed [10:0]    diff;

    function automatic logic signed [2:0] gray_lvl(input logic [1:0] b);
        case (b)
            2'b00:   gray_lvl = 3'b101;  // -3
            2'b01:   gray_lvl = 3'b111;  // -1
            2'b11:   gray_lvl = 3'b001;  // +1
            default: gray_lvl = 3'b011;  // +3
        endcase
    endfunction

    assign xfer = sym_valid & sym_ready;
    assign run  = (state == RUN);

    // sym_ready is registered as the decode of the next state, so it never depends on sym_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lvl_i     <= '0;
            lvl_q     <= '0;
            sym_ready <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    sym_ready <= 1'b1;
                    if (xfer) begin
                        lvl_i     <= gray_lvl(sym[3:2]);
                        lvl_q     <= gray_lvl(sym[1:0]);
                        cnt       <= '0;
                        state     <= RUN;
                        sym_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (xfer) begin
                            lvl_i     <= gray_lvl(sym[3:2]);
                            lvl_q     <= gray_lvl(sym[1:0]);
                            sym_ready <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            underrun  <= 1'b1;
                            sym_ready <= 1'b1;
                        end
                    end else begin
                        cnt       <= cnt + 1'b1;
                        sym_ready <= ((cnt + 1'b1) == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // 3b x 8b signed products fit in 10 bits exactly (|max| = 3*128)
    assign prod_i = $signed({{7{lvl_i[2]}}, lvl_i}) * $signed({{2{cos[7]}}, cos});
    assign prod_q = $signed({{7{lvl_q[2]}}, lvl_q}) * $signed({{2{sin[7]}}, sin});
    assign diff   = $signed({pi[9], pi}) - $signed({pq[9], pq});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
            pi       <= '0;
            pq       <= '0;
            mod_out  <= '0;
        end else begin
            vld_pipe[1] <= run;
            sop_pipe[1] <= run && (cnt == '0);
            pi          <= run ? prod_i : '0;
            pq          <= run ? prod_q : '0;
            vld_pipe[2] <= vld_pipe[1];
            sop_pipe[2] <= sop_pipe[1];
            mod_out     <= vld_pipe[1] ? diff : '0;
        end
    end

    assign mod_valid = vld_pipe[STAGES];
    assign sym_start = sop_pipe[STAGES];
endmodule

// File: tb/tb_qam16_mod.sv
// Directed and model-checked bench for qam16_mod at SPS=8 and SPS=2.
module tb_qam16_mod;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sv8, sv2;
    logic [3:0] sym8, sym2;
    logic signed [7:0] cos8, sin8, cos2, sin2;
    logic rdy8, rdy2, mv8, mv2, ss8, ss2, ur8, ur2;
    logic signed [10:0] mo8, mo2;

    int n_cmp = 0;
    int n_bad = 0;

    qam16_mod #(.SPS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sym_valid(sv8), .sym(sym8), .sym_ready(rdy8),
        .cos(cos8), .sin(sin8), .mod_out(mo8), .mod_valid(mv8), .sym_start(ss8), .underrun(ur8)
    );
    qam16_mod #(.SPS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sym_valid(sv2), .sym(sym2), .sym_ready(rdy2),
        .cos(cos2), .sin(sin2), .mod_out(mo2), .mod_valid(mv2), .sym_start(ss2), .underrun(ur2)
    );

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({mv8, ss8, ur8, rdy8} !== 4'b0) begin n_bad++; $display("FAIL rst_flags8: got %b want 0000", {mv8, ss8, ur8, rdy8}); end
        n_cmp++; if (mo8 !== 11'sd0) begin n_bad++; $display("FAIL rst_mod_out8: got %0d want 0", mo8); end
        n_cmp++; if ({mv2, ss2, ur2, rdy2} !== 4'b0) begin n_bad++; $display("FAIL rst_flags2: got %b want 0000", {mv2, ss2, ur2, rdy2}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdy8 !== 1'b1) begin n_bad++; $display("FAIL rst_ready8: got %b want 1", rdy8); end
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL rst_ready2: got %b want 1", rdy2); end
    endtask

    // single symbol then idle: 8 samples, one underrun, drain to zero
    task automatic test_single();
        cos8 = 8'sd127; sin8 = 8'sd0;
        sv8 = 1'b1; sym8 = 4'b1000;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) sv8 = 1'b0;
            n_cmp++; if (mv8 !== (i >= 2 && i <= 9)) begin n_bad++; $display("FAIL single_valid[%0d]: got %b want %b", i, mv8, (i >= 2 && i <= 9)); end
            n_cmp++; if (mo8 !== ((i >= 2 && i <= 9) ? 11'sd381 : 11'sd0)) begin n_bad++; $display("FAIL single_out[%0d]: got %0d want %0d", i, mo8, (i >= 2 && i <= 9) ? 381 : 0); end
            n_cmp++; if (ss8 !== (i == 2)) begin n_bad++; $display("FAIL single_start[%0d]: got %b want %b", i, ss8, (i == 2)); end
            n_cmp++; if (ur8 !== (i == 8)) begin n_bad++; $display("FAIL single_underrun[%0d]: got %b want %b", i, ur8, (i == 8)); end
            n_cmp++; if (rdy8 !== (i >= 7)) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, rdy8, (i >= 7)); end
        end
    endtask

    task automatic test_extremes();
        logic [3:0]        t_sym [4] = '{4'b0000, 4'b1010, 4'b1000, 4'b0000};
        logic signed [7:0] t_cos [4] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        logic signed [7:0] t_sin [4] = '{8'sd127, 8'sd127, -8'sd128, -8'sd128};
        int                t_exp [4] = '{765, -765, -768, 0};
        for (int k = 0; k < 4; k++) begin
            cos8 = t_cos[k]; sin8 = t_sin[k];
            sv8 = 1'b1; sym8 = t_sym[k];
            @(negedge clk);
            for (int i = 0; i < 12; i++) begin
                if (i > 0) @(negedge clk);
                if (i == 0) sv8 = 1'b0;
                n_cmp++; if (mv8 !== (i >= 2 && i <= 9)) begin n_bad++; $display("FAIL ext%0d_valid[%0d]: got %b want %b", k, i, mv8, (i >= 2 && i <= 9)); end
                n_cmp++; if (mo8 !== ((i >= 2 && i <= 9) ? t_exp[k] : 0)) begin n_bad++; $display("FAIL ext%0d_out[%0d]: got %0d want %0d", k, i, mo8, (i >= 2 && i <= 9) ? t_exp[k] : 0); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] syms [4] = '{4'd8, 4'd7, 4'd13, 4'd11};
        int         vals [4] = '{150, -50, 50, 350};
        bit v;
        cos8 = 8'sd100; sin8 = -8'sd50;
        sv8 = 1'b1; sym8 = syms[0];
        @(negedge clk);
        for (int i = 0; i < 36; i++) begin
            if (i > 0) @(negedge clk);
            if (i % 8 == 0 && i < 24) sym8 = syms[i / 8 + 1];
            if (i == 24) sv8 = 1'b0;
            v = (i >= 2 && i <= 33);
            n_cmp++; if (mv8 !== v) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, mv8, v); end
            n_cmp++; if (mo8 !== (v ? vals[(i - 2) / 8] : 0)) begin n_bad++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, mo8, v ? vals[(i - 2) / 8] : 0); end
            n_cmp++; if (ss8 !== (v && (i - 2) % 8 == 0)) begin n_bad++; $display("FAIL b2b_start[%0d]: got %b want %b", i, ss8, (v && (i - 2) % 8 == 0)); end
            n_cmp++; if (ur8 !== (i == 32)) begin n_bad++; $display("FAIL b2b_underrun[%0d]: got %b want %b", i, ur8, (i == 32)); end
            n_cmp++; if (rdy8 !== (i % 8 == 7 || i >= 32)) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, rdy8, (i % 8 == 7 || i >= 32)); end
        end
    endtask

    task automatic test_reset_mid();
        cos8 = 8'sd127; sin8 = 8'sd0;
        sv8 = 1'b1; sym8 = 4'b1000;
        @(negedge clk);
        sv8 = 1'b0;
        for (int i = 1; i <= 5; i++) @(negedge clk);
        n_cmp++; if (mo8 !== 11'sd381) begin n_bad++; $display("FAIL mid_pre_out: got %0d want 381", mo8); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({mv8, ss8, ur8, rdy8} !== 4'b0) begin n_bad++; $display("FAIL mid_async_flags: got %b want 0000", {mv8, ss8, ur8, rdy8}); end
        n_cmp++; if (mo8 !== 11'sd0) begin n_bad++; $display("FAIL mid_async_out: got %0d want 0", mo8); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (mv8 !== 1'b0 || mo8 !== 11'sd0) begin n_bad++; $display("FAIL mid_flush[%0d]: got %b/%0d want 0/0", i, mv8, mo8); end
        end
        sv8 = 1'b1; sym8 = 4'b1101;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) sv8 = 1'b0;
            n_cmp++; if (mv8 !== (i >= 2 && i <= 9)) begin n_bad++; $display("FAIL mid_valid[%0d]: got %b want %b", i, mv8, (i >= 2 && i <= 9)); end
            n_cmp++; if (mo8 !== ((i >= 2 && i <= 9) ? 11'sd127 : 11'sd0)) begin n_bad++; $display("FAIL mid_out[%0d]: got %0d want %0d", i, mo8, (i >= 2 && i <= 9) ? 127 : 0); end
            n_cmp++; if (ss8 !== (i == 2)) begin n_bad++; $display("FAIL mid_start[%0d]: got %b want %b", i, ss8, (i == 2)); end
        end
    endtask

    // cycle model: state/counter/ready plus a 2-deep expected-output pipe
    task automatic test_random(input int sps, input int ncyc);
        int mst = 0, mcnt = 0, mi = 0, mq = 0;
        bit mrdy = 1'b1, mur = 1'b0, xfer, sv;
        bit d1v = 1'b0, d2v = 1'b0, d1s = 1'b0, d2s = 1'b0;
        int d1 = 0, d2 = 0;
        logic [3:0] s;
        logic signed [7:0] c, sn;
        logic o_rdy, o_mv, o_ss, o_ur;
        logic signed [10:0] o_mo;
        for (int k = 0; k < ncyc + sps + 4; k++) begin
            o_rdy = (sps == 8) ? rdy8 : rdy2;
            o_mv  = (sps == 8) ? mv8  : mv2;
            o_ss  = (sps == 8) ? ss8  : ss2;
            o_ur  = (sps == 8) ? ur8  : ur2;
            o_mo  = (sps == 8) ? mo8  : mo2;
            n_cmp++; if (o_mo !== (d2v ? d2 : 0)) begin n_bad++; $display("FAIL rand%0d_out[%0d]: got %0d want %0d", sps, k, o_mo, d2v ? d2 : 0); end
            n_cmp++; if (o_mv !== d2v) begin n_bad++; $display("FAIL rand%0d_valid[%0d]: got %b want %b", sps, k, o_mv, d2v); end
            n_cmp++; if (o_ss !== d2s) begin n_bad++; $display("FAIL rand%0d_start[%0d]: got %b want %b", sps, k, o_ss, d2s); end
            n_cmp++; if (o_ur !== mur) begin n_bad++; $display("FAIL rand%0d_underrun[%0d]: got %b want %b", sps, k, o_ur, mur); end
            n_cmp++; if (o_rdy !== mrdy) begin n_bad++; $display("FAIL rand%0d_ready[%0d]: got %b want %b", sps, k, o_rdy, mrdy); end
            sv = (k < ncyc) && ($urandom_range(0, 9) < 7);
            s = 4'($urandom); c = 8'($urandom); sn = 8'($urandom);
            if (sps == 8) begin sv8 = sv; sym8 = s; cos8 = c; sin8 = sn; end
            else          begin sv2 = sv; sym2 = s; cos2 = c; sin2 = sn; end
            xfer = sv && mrdy;
            d2v = d1v; d2 = d1; d2s = d1s;
            d1v = (mst == 1); d1s = (mst == 1 && mcnt == 0);
            d1  = (mst == 1) ? mi * c - mq * sn : 0;
            mur = 1'b0;
            if (mst == 0) begin
                if (xfer) begin mst = 1; mcnt = 0; mi = lvl(s[3:2]); mq = lvl(s[1:0]); end
            end else if (mcnt == sps - 1) begin
                mcnt = 0;
                if (xfer) begin mi = lvl(s[3:2]); mq = lvl(s[1:0]); end
                else begin mst = 0; mur = 1'b1; end
            end else begin
                mcnt++;
            end
            mrdy = (mst == 0) || (mcnt == sps - 1);
            @(negedge clk);
        end
    endtask

    initial begin
        sv8 = 1'b0; sv2 = 1'b0; sym8 = '0; sym2 = '0;
        cos8 = '0; sin8 = '0; cos2 = '0; sin2 = '0;
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_random(8, 400);
        test_random(2, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
